// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state type and helpers for the 8-point FFT
package fft_pkg;

   localparam int FFT_N    = 8;
   localparam int FFT_W    = 9;
   localparam int FFT_LOGN = 3;
   localparam int KW       = 2;

   typedef enum logic [1:0] {LOAD, CALC, WAIT, OUT} fft_state_e;

   typedef logic [KW-1:0] twiddle_idx_t;

   function automatic logic [FFT_LOGN-1:0] bitrev3(input logic [FFT_LOGN-1:0] a);
      return {a[0], a[1], a[2]};
   endfunction

endpackage

// File: rtl/butterfly_unit.sv
// rtl/butterfly_unit.sv - radix-2 DIT butterfly with W8^k twiddle, halved and registered outputs
module butterfly_unit
   import fft_pkg::*;
#(
   parameter int W = FFT_W
)
(
   input  logic         clk,
   input  logic         rst,
   input  twiddle_idx_t k,
   input  logic [W-1:0] x0_re,
   input  logic [W-1:0] x0_im,
   input  logic [W-1:0] x1_re,
   input  logic [W-1:0] x1_im,
   output logic [W-1:0] a0_re,
   output logic [W-1:0] a0_im,
   output logic [W-1:0] a1_re,
   output logic [W-1:0] a1_im
);

   localparam int PW = 32;
   // cos(pi/4) in Q8; products are truncated toward -inf by the arithmetic shift
   localparam logic signed [PW-1:0] C45 = 32'sd181;

   logic signed [PW-1:0] x0r, x0i, x1r, x1i, tr, ti;
   logic [W-1:0] a0_re_d, a0_im_d, a1_re_d, a1_im_d;
   logic [W-1:0] a0_re_q, a0_im_q, a1_re_q, a1_im_q;

   function automatic logic signed [PW-1:0] sext(input logic [W-1:0] v);
      return {{(PW-W){v[W-1]}}, v};
   endfunction

   always_comb begin
      x0r = sext(x0_re);
      x0i = sext(x0_im);
      x1r = sext(x1_re);
      x1i = sext(x1_im);
      tr  = x1r;
      ti  = x1i;
      case (k)
         2'd1: begin
            tr = (C45 * (x1r + x1i)) >>> 8;
            ti = (C45 * (x1i - x1r)) >>> 8;
         end
         2'd2: begin
            tr = x1i;
            ti = -x1r;
         end
         2'd3: begin
            tr = (C45 * (x1i - x1r)) >>> 8;
            ti = (C45 * (-x1r - x1i)) >>> 8;
         end
         default: ;
      endcase
      // Halving keeps the 3-stage transform inside W bits; overflow simply wraps
      a0_re_d = W'((x0r + tr) >>> 1);
      a0_im_d = W'((x0i + ti) >>> 1);
      a1_re_d = W'((x0r - tr) >>> 1);
      a1_im_d = W'((x0i - ti) >>> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a0_re_q <= '0;
         a0_im_q <= '0;
         a1_re_q <= '0;
         a1_im_q <= '0;
      end else begin
         a0_re_q <= a0_re_d;
         a0_im_q <= a0_im_d;
         a1_re_q <= a1_re_d;
         a1_im_q <= a1_im_d;
      end
   end

   assign a0_re = a0_re_q;
   assign a0_im = a0_im_q;
   assign a1_re = a1_re_q;
   assign a1_im = a1_im_q;

endmodule

// File: rtl/fft8_controller.sv
// rtl/fft8_controller.sv - load/compute/unload sequencer and in-place memory for an 8-point FFT
module fft8_controller
   import fft_pkg::*;
#(
   parameter int N = FFT_N,
   parameter int W = FFT_W
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         busy
);

   localparam int AW = FFT_LOGN;

   fft_state_e   state_q, state_d;
   logic [AW-1:0] n_q, n_d, m_q, m_d;
   logic [1:0]    s_q, s_d, b_q, b_d;
   logic          wb_q, wb_d;
   logic [AW-1:0] top_q, top_d, bot_q, bot_d;
   logic [AW-1:0] top_a, bot_a;
   twiddle_idx_t  k;
   logic          in_xfer, out_xfer;

   logic [W-1:0] mem_re_q [N];
   logic [W-1:0] mem_im_q [N];
   logic [W-1:0] mem_re_d [N];
   logic [W-1:0] mem_im_d [N];

   logic [W-1:0] a0_re, a0_im, a1_re, a1_im;

   assign in_xfer  = (state_q == LOAD) && in_valid;
   assign out_xfer = (state_q == OUT) && out_ready;

   // Stage s pairs addresses that differ in bit s; j (the low s bits of b) selects the twiddle
   always_comb begin
      top_a = '0;
      bot_a = '0;
      k     = '0;
      case (s_q)
         2'd0: begin
            top_a = {b_q, 1'b0};
            bot_a = {b_q, 1'b1};
            k     = 2'd0;
         end
         2'd1: begin
            top_a = {b_q[1], 1'b0, b_q[0]};
            bot_a = {b_q[1], 1'b1, b_q[0]};
            k     = {b_q[0], 1'b0};
         end
         default: begin
            top_a = {1'b0, b_q};
            bot_a = {1'b1, b_q};
            k     = b_q;
         end
      endcase
   end

   butterfly_unit #(.W(W)) u_bfly (
      .clk   (clk),
      .rst   (rst),
      .k     (k),
      .x0_re (mem_re_q[top_a]),
      .x0_im (mem_im_q[top_a]),
      .x1_re (mem_re_q[bot_a]),
      .x1_im (mem_im_q[bot_a]),
      .a0_re (a0_re),
      .a0_im (a0_im),
      .a1_re (a1_re),
      .a1_im (a1_im)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         n_q     <= '0;
         m_q     <= '0;
         s_q     <= '0;
         b_q     <= '0;
         wb_q    <= 1'b0;
         top_q   <= '0;
         bot_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         m_q     <= m_d;
         s_q     <= s_d;
         b_q     <= b_d;
         wb_q    <= wb_d;
         top_q   <= top_d;
         bot_q   <= bot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      m_d     = m_q;
      s_d     = s_q;
      b_d     = b_q;
      wb_d    = (state_q == CALC);
      top_d   = top_a;
      bot_d   = bot_a;
      case (state_q)
         LOAD: begin
            if (in_xfer) begin
               n_d = n_q + 3'd1;
               if (n_q == 3'd7) state_d = CALC;
            end
         end
         CALC: begin
            b_d = b_q + 2'd1;
            if (b_q == 2'd3) state_d = WAIT;
         end
         WAIT: begin
            if (s_q == 2'd2) begin
               s_d     = 2'd0;
               state_d = OUT;
            end else begin
               s_d     = s_q + 2'd1;
               state_d = CALC;
            end
         end
         default: begin
            if (out_xfer) begin
               m_d = m_q + 3'd1;
               if (m_q == 3'd7) state_d = LOAD;
            end
         end
      endcase
   end

   // Memory has no reset: a fresh frame overwrites every word before it is read
   always_comb begin
      mem_re_d = mem_re_q;
      mem_im_d = mem_im_q;
      if (in_xfer) begin
         mem_re_d[bitrev3(n_q)] = in_re;
         mem_im_d[bitrev3(n_q)] = in_im;
      end
      if (wb_q) begin
         mem_re_d[top_q] = a0_re;
         mem_im_d[top_q] = a0_im;
         mem_re_d[bot_q] = a1_re;
         mem_im_d[bot_q] = a1_im;
      end
   end

   always_ff @(posedge clk) begin
      mem_re_q <= mem_re_d;
      mem_im_q <= mem_im_d;
   end

   always_comb begin
      in_ready  = (state_q == LOAD);
      out_valid = (state_q == OUT);
      busy      = (state_q != LOAD);
      out_re    = out_valid ? mem_re_q[m_q] : '0;
      out_im    = out_valid ? mem_im_q[m_q] : '0;
   end

endmodule
